serial_frame_rx: RTL and testbench

//   Asynchronous-serial frame receiver (start bit, DATA_W data bits LSB first, one stop bit).

---
 rtl/serial_frame_rx_if.sv | 33 +++
 rtl/serial_frame_rx.sv | 135 +++++++++++++
 tb/tb_serial_frame_rx.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Receiver output bundle: received word, its valid/ready handshake and status pulses.
// Latency: none, this is wiring only.
// Backpressure: ready is driven by the consumer; the receiver holds the word until ready.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              ready_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  // Receiver side: produces the word and status, consumes ready.
  modport master (
    input  ready_in,
    output data_out,
    output valid_out,
    output frame_err,
    output overrun,
    output busy
  );

  // Consumer side: accepts the word and observes status.
  modport slave (
    output ready_in,
    input  data_out,
    input  valid_out,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Async-serial frame receiver (start, DATA_W data bits LSB first, one stop bit).
// Latency: valid rises H+(DATA_W+1)*CLKS_PER_BIT+1 cycles after the start-bit falling edge.
// Backpressure: a held word is kept; a frame finishing while it is unaccepted is dropped and flagged.
module serial_frame_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_in,
  serial_frame_rx_if.master   rx
);

  localparam int H     = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);

  // Counter values at which the line is sampled: mid start bit, then every full bit period.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;

  // Frame FSM with registered outputs; sample points come from cnt wrapping at each sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx.data_out  <= '0;
      rx.valid_out <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;
      rx.busy      <= 1'b0;
    end else begin
      // Status flags are single-cycle pulses.
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;

      // Handshake transfer; a delivery in the same cycle below overrides this.
      if (rx.valid_out && rx.ready_in) begin
        rx.valid_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!d_in) begin
            state   <= START;
            cnt     <= '0;
            rx.busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!d_in) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state   <= IDLE;
              rx.busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {d_in, shreg[DATA_W-1:1]};
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (d_in) begin
              state   <= IDLE;
              rx.busy <= 1'b0;
              if (!rx.valid_out || rx.ready_in) begin
                rx.data_out  <= shreg;
                rx.valid_out <= 1'b1;
              end else begin
                rx.overrun <= 1'b1;
              end
            end else begin
              rx.frame_err <= 1'b1;
              state        <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          // After a bad stop bit, hold off until the line is released.
          if (d_in) begin
            state   <= IDLE;
            rx.busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          rx.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx: builds a line/reset/ready schedule, predicts outputs from frame rules.
// Latency: checks every cycle against a per-edge expectation table.
// Backpressure: ready patterns are constant 0, constant 1 or random per segment.
module tb_serial_frame_rx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
  localparam int H      = CPB / 2;

  logic clk = 1'b0;
  logic rst;
  logic d_in;

  always #5 clk = ~clk;

  serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

  serial_frame_rx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .d_in(d_in),
    .rx  (bus)
  );

  // Stimulus schedule, one entry per posedge.
  bit line_q[$];
  bit rst_q[$];
  bit rdy_q[$];
  int rdy_mode;

  // Expectations derived from the schedule.
  bit                ex_busy[];
  int                ev_kind[];  // 0 none, 1 stop bit good, 2 stop bit bad
  logic [DATA_W-1:0] ev_word[];

  typedef struct {
    int          edge_n;
    int          sig;      // 0 busy, 1 valid, 2 data, 3 frame_err, 4 overrun
    logic [31:0] val;
  } lit_t;
  lit_t lit_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cur_edge = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, cur_edge, got, exp);
    end
  endtask

  function automatic bit next_rdy();
    case (rdy_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic push_r(bit l, bit r, bit rd);
    line_q.push_back(l);
    rst_q.push_back(r);
    rdy_q.push_back(rd);
  endtask

  task automatic push(bit l, bit r);
    push_r(l, r, next_rdy());
  endtask

  task automatic add_idle(int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0);
  endtask

  task automatic add_reset(int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b1);
  endtask

  task automatic lit(int e, int sig, logic [31:0] val);
    lit_t l;
    l.edge_n = e;
    l.sig    = sig;
    l.val    = val;
    lit_q.push_back(l);
  endtask

  // Line level k cycles after the start-bit falling edge of a frame.
  function automatic bit frame_bit(logic [DATA_W-1:0] w, bit stop, int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= DATA_W) return w[b-1];
    return stop;
  endfunction

  task automatic add_frame(logic [DATA_W-1:0] w, bit stop, int low_extra, output int t0);
    t0 = line_q.size();
    for (int k = 0; k < (DATA_W + 2) * CPB; k++) push(frame_bit(w, stop, k), 1'b0);
    if (!stop) begin
      for (int k = 0; k < low_extra; k++) push(1'b0, 1'b0);
    end
  endtask

  task automatic add_aborted(logic [DATA_W-1:0] w, int cut, output int r_edge);
    for (int k = 0; k < cut; k++) push(frame_bit(w, 1'b1, k), 1'b0);
    r_edge = line_q.size();
    push(1'b1, 1'b1);
  endtask

  task automatic add_glitch(int g);
    for (int k = 0; k < g; k++) push(1'b0, 1'b0);
    add_idle(H + 1);
  endtask

  // Walk the line as a receiver would read it: find start edges, read the sample
  // points, and record busy spans and end-of-frame outcomes per edge.
  function automatic void build_model();
    int n;
    int p;
    n       = line_q.size();
    ex_busy = new[n];
    ev_kind = new[n];
    ev_word = new[n];
    for (int k = 0; k < n; k++) begin
      ex_busy[k] = 1'b0;
      ev_kind[k] = 0;
      ev_word[k] = '0;
    end
    p = 0;
    while (p < n) begin
      int s;
      int ts;
      int e;
      int kind;
      int r;
      logic [DATA_W-1:0] w;
      if (rst_q[p] || line_q[p]) begin
        p++;
        continue;
      end
      s    = p + H;
      ts   = s + (DATA_W + 1) * CPB;
      kind = 0;
      w    = '0;
      if (s >= n) begin
        e = n;
      end else if (line_q[s]) begin
        e = s;
      end else begin
        for (int i = 0; i < DATA_W; i++) begin
          if (s + (i + 1) * CPB < n) w[i] = line_q[s + (i + 1) * CPB];
        end
        if (ts >= n) begin
          e = n;
        end else if (line_q[ts]) begin
          e    = ts;
          kind = 1;
        end else begin
          kind = 2;
          e    = ts + 1;
          while (e < n && !line_q[e]) e++;
        end
      end
      r = -1;
      for (int k = p; k <= e && k < n; k++) begin
        if (rst_q[k]) begin
          r = k;
          break;
        end
      end
      if (r >= 0) begin
        if (!(kind == 2 && r > ts)) kind = 0;
        e = r;
      end
      for (int k = p; k < e && k < n; k++) ex_busy[k] = 1'b1;
      if (kind != 0) begin
        ev_kind[ts] = kind;
        ev_word[ts] = w;
      end
      p = e + 1;
    end
  endfunction

  initial begin
    int t0;
    int t5b;
    int tr;
    int r6;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_fe;
    logic              m_ov;
    logic              v_before;

    // 1: reset then long idle
    rdy_mode = 1;
    add_reset(2);
    add_idle(20);
    lit(1, 0, 0);
    lit(1, 1, 0);
    lit(21, 0, 0);

    // 2: good frame, consumer always ready
    add_frame(8'hA5, 1'b1, 0, t0);
    lit(t0, 0, 1);
    lit(t0 + 37, 0, 1);
    lit(t0 + 38, 0, 0);
    lit(t0 + 38, 1, 1);
    lit(t0 + 38, 2, 32'hA5);
    lit(t0 + 39, 1, 0);
    add_idle(6);

    // 3: one-cycle glitch
    t0 = line_q.size();
    add_glitch(1);
    lit(t0 + 2, 0, 0);
    lit(t0 + 2, 1, 0);
    add_idle(4);

    // 4: bad stop bit, line stays low a few cycles longer
    add_frame(8'h3C, 1'b0, 3, t0);
    lit(t0 + 38, 3, 1);
    lit(t0 + 38, 1, 0);
    lit(t0 + 39, 3, 0);
    lit(t0 + 39, 0, 1);
    add_idle(6);

    // 5: back-to-back frames with the consumer stalled, then one ready cycle
    rdy_mode = 0;
    add_frame(8'h11, 1'b1, 0, t0);
    add_frame(8'h22, 1'b1, 0, t5b);
    lit(t0 + 38, 1, 1);
    lit(t0 + 38, 2, 32'h11);
    lit(t5b + 38, 4, 1);
    lit(t5b + 38, 2, 32'h11);
    lit(t5b + 38, 1, 1);
    lit(t5b + 39, 4, 0);
    add_idle(3);
    tr = line_q.size();
    push_r(1'b1, 1'b0, 1'b1);
    lit(tr - 1, 1, 1);
    lit(tr, 1, 0);
    add_idle(4);

    // 6: reset during data bit 3, then a clean frame
    rdy_mode = 1;
    add_aborted(8'hC3, 16, r6);
    lit(r6, 0, 0);
    lit(r6, 1, 0);
    lit(r6, 2, 0);
    add_idle(5);
    add_frame(8'h5A, 1'b1, 0, t0);
    lit(t0 + 38, 1, 1);
    lit(t0 + 38, 2, 32'h5A);
    add_idle(4);

    // Random mix of frames, errors, glitches, aborts and gaps
    for (int it = 0; it < 30; it++) begin
      int act;
      rdy_mode = int'($urandom_range(0, 2));
      act      = int'($urandom_range(0, 9));
      if (act <= 5) begin
        add_frame(DATA_W'($urandom), 1'b1, 0, t0);
      end else if (act == 6) begin
        add_frame(DATA_W'($urandom), 1'b0, int'($urandom_range(0, 5)), t0);
      end else if (act == 7) begin
        add_glitch(int'($urandom_range(1, H - 1)));
      end else if (act == 8) begin
        add_aborted(DATA_W'($urandom), int'($urandom_range(1, (DATA_W + 2) * CPB - 1)), t0);
      end else begin
        add_idle(int'($urandom_range(1, 8)));
      end
      add_idle(int'($urandom_range(0, 6)));
    end
    add_idle(10);

    build_model();

    m_valid = 1'b0;
    m_data  = '0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    rst          = 1'b1;
    d_in         = 1'b1;
    bus.ready_in = 1'b0;

    for (int n = 0; n < line_q.size(); n++) begin
      rst          = rst_q[n];
      d_in         = line_q[n];
      bus.ready_in = rdy_q[n];
      @(posedge clk);
      cur_edge = n;
      if (rst_q[n]) begin
        m_valid = 1'b0;
        m_data  = '0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
      end else begin
        m_fe     = 1'b0;
        m_ov     = 1'b0;
        v_before = m_valid;
        if (m_valid && rdy_q[n]) m_valid = 1'b0;
        if (ev_kind[n] == 1) begin
          if (!v_before || rdy_q[n]) begin
            m_data  = ev_word[n];
            m_valid = 1'b1;
          end else begin
            m_ov = 1'b1;
          end
        end else if (ev_kind[n] == 2) begin
          m_fe = 1'b1;
        end
      end
      @(negedge clk);
      check("busy", 32'(bus.busy), 32'(ex_busy[n]));
      check("valid_out", 32'(bus.valid_out), 32'(m_valid));
      check("data_out", 32'(bus.data_out), 32'(m_data));
      check("frame_err", 32'(bus.frame_err), 32'(m_fe));
      check("overrun", 32'(bus.overrun), 32'(m_ov));
      foreach (lit_q[i]) begin
        if (lit_q[i].edge_n == n) begin
          case (lit_q[i].sig)
            0:       check("lit_busy", 32'(bus.busy), lit_q[i].val);
            1:       check("lit_valid", 32'(bus.valid_out), lit_q[i].val);
            2:       check("lit_data", 32'(bus.data_out), lit_q[i].val);
            3:       check("lit_frame_err", 32'(bus.frame_err), lit_q[i].val);
            default: check("lit_overrun", 32'(bus.overrun), lit_q[i].val);
          endcase
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
